// File: rtl/peri_display_reader.sv
// Display-side FIFO reader: VGA raster timing plus one RGB565 FIFO read per active pixel.
// All pins come out of a two-stage pipeline, so they lag the raster counters by two clocks.
module peri_display_reader #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned USEDW_W     = 10,
  parameter int unsigned START_LEVEL = 320
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic [15:0]        fifo_rddata,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               fifo_rdreq,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic               lcd_de,
  output logic [15:0]        lcd_rgb,
  output logic               frame_start,
  output logic               underflow
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0]      HSyncEnd  = HW'(H_SYNC);
  localparam logic [HW-1:0]      HActBeg   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0]      HActEnd   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0]      HLast     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]      VSyncEnd  = VW'(V_SYNC);
  localparam logic [VW-1:0]      VActBeg   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0]      VActEnd   = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0]      VLast     = VW'(V_TOTAL - 1);
  localparam logic [USEDW_W-1:0] StartLvl  = USEDW_W'(START_LEVEL);

  typedef enum logic [0:0] {StWaitFill, StRun} state_e;

  state_e        state, next_state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          area, frame_origin, uf_now;

  // Stage 1 flags and the registered read request
  logic s1_hsync, s1_vsync, s1_de, s1_fs, s1_uf, rd_vld_d;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      state <= StWaitFill;
    end else begin
      state <= next_state;
      if (h_cnt == HLast) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VLast) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
    area         = (h_cnt >= HActBeg) && (h_cnt < HActEnd) &&
                   (v_cnt >= VActBeg) && (v_cnt < VActEnd);
    fifo_rdreq   = 1'b0;
    uf_now       = 1'b0;
    unique case (state)
      StWaitFill: begin
        if (frame_origin && (fifo_usedw >= StartLvl)) next_state = StRun;
      end
      StRun: begin
        fifo_rdreq = area && !fifo_empty;
        uf_now     = area && fifo_empty;
      end
      default: next_state = StWaitFill;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
      s1_de    <= 1'b0;
      s1_fs    <= 1'b0;
      s1_uf    <= 1'b0;
      rd_vld_d <= 1'b0;
    end else begin
      s1_hsync <= !(h_cnt < HSyncEnd);
      s1_vsync <= !(v_cnt < VSyncEnd);
      s1_de    <= area;
      s1_fs    <= frame_origin;
      s1_uf    <= uf_now;
      rd_vld_d <= fifo_rdreq;
    end
  end

  // fifo_rddata becomes valid alongside rd_vld_d, so both land on the pins together
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_rgb     <= 16'h0000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      lcd_hsync   <= s1_hsync;
      lcd_vsync   <= s1_vsync;
      lcd_de      <= s1_de;
      lcd_rgb     <= rd_vld_d ? fifo_rddata : 16'h0000;
      frame_start <= s1_fs;
      underflow   <= s1_uf;
    end
  end

endmodule

// File: tb/tb_peri_display_reader.sv
// Directed bench for peri_display_reader with a 14x7 raster (98 clocks per frame).
module tb_peri_display_reader;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [15:0] fifo_rddata = 16'h0000;
  logic        fifo_empty;
  logic [9:0]  fifo_usedw;
  logic        fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, frame_start, underflow;
  logic [15:0] lcd_rgb;

  int n_tests = 0;
  int n_fail  = 0;

  peri_display_reader #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .USEDW_W(10), .START_LEVEL(16)
  ) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .fifo_usedw  (fifo_usedw),
    .fifo_rdreq  (fifo_rdreq),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 sclk = ~sclk;

  // Normal-mode FIFO model holding the ramp 1, 2, 3, ...
  logic [15:0] word = 16'd1;
  always @(posedge sclk) begin
    if (fifo_rdreq) begin
      fifo_rddata <= word;
      word        <= word + 16'd1;
    end
  end

  typedef struct {
    int          cyc;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] pins();
    return {fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, frame_start, underflow, lcd_rgb};
  endfunction

  localparam logic [21:0] IdlePins = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

  int hs_low[4], vs_low[4], de_hi[4], fs_cnt[4], uf_cnt[4], rd_cnt[4];
  int rd_outside = 0;
  logic [15:0] exp_px = 16'd1;

  initial begin
    // {pin cycle, hsync, vsync, de, frame_start, rgb}; cycle 0 = counters at (0,0)
    vecs[0]  = '{2,   1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[1]  = '{34,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{100, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[3]  = '{101, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{102, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{114, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{132, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001};
    vecs[7]  = '{139, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0008};
    vecs[8]  = '{140, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{146, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0009};
    vecs[10] = '{181, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0020};
    vecs[11] = '{198, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      hs_low[i] = 0; vs_low[i] = 0; de_hi[i] = 0; fs_cnt[i] = 0; uf_cnt[i] = 0; rd_cnt[i] = 0;
    end

    // Reset held with random inputs
    s_rst_n    = 1'b0;
    fifo_empty = 1'b0;
    fifo_usedw = '0;
    for (int i = 0; i < 5; i++) begin
      fifo_empty = 1'($urandom_range(0, 1));
      fifo_usedw = 10'($urandom_range(0, 1023));
      @(negedge sclk);
      check("reset_pins", 32'(pins()), 32'(IdlePins));
    end
    @(posedge sclk);
    #1 s_rst_n = 1'b1;

    for (int cyc = 0; cyc <= 428; cyc++) begin
      fifo_usedw = (cyc < 50) ? 10'd15 : 10'd16;
      fifo_empty = (cyc >= 230 && cyc <= 232);
      @(negedge sclk);
      for (int i = 0; i < 12; i++) begin
        if (vecs[i].cyc == cyc) begin
          check("vec_pins", 32'({lcd_hsync, lcd_vsync, lcd_de, frame_start, lcd_rgb}),
                32'({vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].fs, vecs[i].rgb}));
        end
      end
      if (cyc <= 391) begin
        int h, v;
        logic in_area;
        h = cyc % 14;
        v = (cyc / 14) % 7;
        in_area = (h >= 4 && h < 12 && v >= 2 && v < 6);
        if (fifo_rdreq) rd_cnt[cyc / 98]++;
        if (fifo_rdreq && !in_area) rd_outside++;
      end
      if (cyc >= 2 && cyc <= 393) begin
        int pf;
        pf = (cyc - 2) / 98;
        if (!lcd_hsync) hs_low[pf]++;
        if (!lcd_vsync) vs_low[pf]++;
        if (lcd_de) de_hi[pf]++;
        if (frame_start) fs_cnt[pf]++;
        if (underflow) uf_cnt[pf]++;
      end
      if (cyc >= 229 && cyc <= 233) check("uf_rdreq", 32'(fifo_rdreq), 32'(cyc == 229 || cyc == 233));
      if (cyc >= 232 && cyc <= 234) begin
        check("uf_pixel", 32'({lcd_de, underflow, lcd_rgb}), 32'({1'b1, 1'b1, 16'h0000}));
      end else if (lcd_de && cyc < 100) begin
        check("fill_gate_rgb", 32'(lcd_rgb), 32'h0);
      end else if (lcd_de) begin
        check("ramp_rgb", 32'({underflow, lcd_rgb}), 32'({1'b0, exp_px}));
        exp_px = exp_px + 16'd1;
      end
      if (cyc == 428) check("pre_reset_de", 32'(lcd_de), 32'h1);
      if (cyc < 428) begin
        @(posedge sclk);
        #1;
      end
    end

    // Frame statistics: WAIT_FILL, full stream, 3-pixel underflow, full stream
    for (int f = 0; f < 4; f++) begin
      check("hsync_low", 32'(hs_low[f]), 32'd14);
      check("vsync_low", 32'(vs_low[f]), 32'd14);
      check("de_count", 32'(de_hi[f]), 32'd32);
      check("frame_start_cnt", 32'(fs_cnt[f]), 32'd1);
      check("rdreq_count", 32'(rd_cnt[f]), (f == 0) ? 32'd0 : (f == 2) ? 32'd29 : 32'd32);
      check("uf_count", 32'(uf_cnt[f]), (f == 2) ? 32'd3 : 32'd0);
    end
    check("rdreq_outside", 32'(rd_outside), 32'd0);

    // Asynchronous reset mid-active: pins must snap without a clock edge
    #1 s_rst_n = 1'b0;
    #1 check("async_reset", 32'(pins()), 32'(IdlePins));
    repeat (2) @(posedge sclk);
    #1 s_rst_n = 1'b1;
    exp_px = word;
    for (int cyc = 0; cyc <= 34; cyc++) begin
      fifo_usedw = 10'd16;
      fifo_empty = 1'b0;
      @(negedge sclk);
      if (cyc == 1) check("restart_idle", 32'({lcd_hsync, frame_start}), 32'({1'b1, 1'b0}));
      if (cyc == 2) check("restart_fs", 32'({lcd_hsync, lcd_vsync, frame_start}), 32'({1'b0, 1'b0, 1'b1}));
      if (cyc == 31) check("restart_rdreq_pre", 32'(fifo_rdreq), 32'h0);
      if (cyc == 32) check("restart_rdreq", 32'(fifo_rdreq), 32'h1);
      if (cyc == 34) check("restart_rgb", 32'({lcd_de, lcd_rgb}), 32'({1'b1, exp_px}));
      if (cyc < 34) begin
        @(posedge sclk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
